line_fill_arbiter: RTL and testbench

Line-level controller that shares the single cache line adapter, and the memory port behind it, between the instruction cache and the data cache. It grants one requester at a time and latches the line-aligned address. For a D-cache miss with a dirty victim, it runs an atomic write-back-then-fill pair. It drives the adapter's `re`/`we`/`toggle` handshake and returns the 256-bit line with a one-cycle acknowledge.

---
 rtl/line_fill_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_line_fill_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter: shares one cache line adapter between the I-cache and
// the D-cache. A dirty D-cache miss runs write-back then fill while keeping
// the grant. The 256-bit line comes back with a one-cycle ack.
// Optional feature macro: LFA_ROUND_ROBIN_EN (round-robin tie break).
// When it is undefined, the D-cache always wins a tie.
module line_fill_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_line,
  input  logic              dc_req,
  input  logic              dc_dirty,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [LINE_W-1:0] dc_wb_line,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_line,
  output logic              cla_re,
  output logic              cla_we,
  output logic              cla_toggle,
  output logic [LINE_W-1:0] cla_wdata,
  input  logic [LINE_W-1:0] cla_rdata,
  input  logic              cla_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              owner,
  output logic              err
);

  localparam int OFF = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_ISSUE,
    S_WB_BUSY,
    S_FILL_ISSUE,
    S_FILL_BUSY,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              toggle_q, toggle_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              ic_ack_q, ic_ack_d;
  logic              dc_ack_q, dc_ack_d;
  logic              err_q, err_d;

  logic              tie_dc;
  logic              pick_dc;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    r[OFF-1:0] = '0;
    return r;
  endfunction

`ifdef LFA_ROUND_ROBIN_EN
  logic rr_q;

  // The tie pointer moves to the requester not served by the transfer now acking.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_q <= 1'b1;
    end else if (state_q == S_ACK) begin
      rr_q <= ~owner_q;
    end
  end

  assign tie_dc = rr_q;
`else
  assign tie_dc = 1'b1;
`endif

  // Arbitration: a lone request always wins. A tie follows the policy bit.
  always_comb begin
    pick_dc = dc_req & (~ic_req | tie_dc);
  end

  // Next-state logic. The grant and the addresses are latched when leaving IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    miss_addr_d = miss_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_line_d   = wb_line_q;
    line_d      = line_q;
    case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d     = pick_dc;
          miss_addr_d = pick_dc ? dc_addr : ic_addr;
          wb_addr_d   = dc_wb_addr;
          wb_line_d   = dc_wb_line;
          state_d     = (pick_dc && dc_dirty) ? S_WB_ISSUE : S_FILL_ISSUE;
        end
      end
      S_WB_ISSUE:   state_d = S_WB_BUSY;
      S_WB_BUSY:    if (cla_ready) state_d = S_FILL_ISSUE;
      S_FILL_ISSUE: state_d = S_FILL_BUSY;
      S_FILL_BUSY: begin
        if (cla_ready) begin
          line_d  = cla_rdata;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are decoded from the next state so that every output is a
  // register that lines up with the state it belongs to.
  always_comb begin
    toggle_d   = (state_d == S_WB_ISSUE) || (state_d == S_FILL_ISSUE);
    we_d       = (state_d == S_WB_ISSUE) || (state_d == S_WB_BUSY);
    re_d       = (state_d == S_FILL_ISSUE) || (state_d == S_FILL_BUSY);
    mem_addr_d = '0;
    if (we_d) begin
      mem_addr_d = align(wb_addr_d);
    end else if (re_d) begin
      mem_addr_d = align(miss_addr_d);
    end
    wdata_d  = we_d ? wb_line_d : '0;
    busy_d   = (state_d != S_IDLE);
    ic_ack_d = (state_d == S_ACK) && !owner_d;
    dc_ack_d = (state_d == S_ACK) && owner_d;
    err_d    = err_q;
    if (cla_ready && ((state_q == S_IDLE) || (state_q == S_WB_ISSUE) ||
                      (state_q == S_FILL_ISSUE) || (state_q == S_ACK))) begin
      err_d = 1'b1;
    end
  end

  // FSM state, latched transfer context and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_line_q   <= '0;
      line_q      <= '0;
      toggle_q    <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      miss_addr_q <= miss_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_line_q   <= wb_line_d;
      line_q      <= line_d;
      toggle_q    <= toggle_d;
      we_q        <= we_d;
      re_q        <= re_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      ic_ack_q    <= ic_ack_d;
      dc_ack_q    <= dc_ack_d;
      err_q       <= err_d;
    end
  end

  assign ic_ack     = ic_ack_q;
  assign dc_ack     = dc_ack_q;
  assign ic_line    = line_q;
  assign dc_line    = line_q;
  assign cla_re     = re_q;
  assign cla_we     = we_q;
  assign cla_toggle = toggle_q;
  assign cla_wdata  = wdata_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign err        = err_q;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Self-checking bench for line_fill_arbiter. A small transaction-level model
// (last requester served plus snapshots of the request fields) predicts the
// winner, the pass sequence, addresses and returned line.
module tb_line_fill_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  logic              CLK;
  logic              RST;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [LINE_W-1:0] ic_line;
  logic              dc_req;
  logic              dc_dirty;
  logic [ADDR_W-1:0] dc_addr;
  logic [ADDR_W-1:0] dc_wb_addr;
  logic [LINE_W-1:0] dc_wb_line;
  logic              dc_ack;
  logic [LINE_W-1:0] dc_line;
  logic              cla_re;
  logic              cla_we;
  logic              cla_toggle;
  logic [LINE_W-1:0] cla_wdata;
  logic [LINE_W-1:0] cla_rdata;
  logic              cla_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              owner;
  logic              err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          last_d = 1'b0;  // last requester served was D-cache

  line_fill_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_line(ic_line),
    .dc_req(dc_req), .dc_dirty(dc_dirty), .dc_addr(dc_addr),
    .dc_wb_addr(dc_wb_addr), .dc_wb_line(dc_wb_line),
    .dc_ack(dc_ack), .dc_line(dc_line),
    .cla_re(cla_re), .cla_we(cla_we), .cla_toggle(cla_toggle),
    .cla_wdata(cla_wdata), .cla_rdata(cla_rdata), .cla_ready(cla_ready),
    .mem_addr(mem_addr), .busy(busy), .owner(owner), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [ADDR_W-1:0] aligned(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Winner predicted from the request pattern and the arbitration policy.
  function automatic bit model_pick(input bit i_req, input bit d_req);
    if (d_req && !i_req) return 1'b1;
    if (i_req && !d_req) return 1'b0;
`ifdef LFA_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".owner"}, owner, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".ic_ack"}, ic_ack, 0);
    chk({tag, ".dc_ack"}, dc_ack, 0);
    chk({tag, ".toggle"}, cla_toggle, 0);
    chk({tag, ".re"}, cla_re, 0);
    chk({tag, ".we"}, cla_we, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".wdata"}, cla_wdata, 0);
    chk({tag, ".ic_line"}, ic_line, 0);
    chk({tag, ".dc_line"}, dc_line, 0);
  endtask

  task automatic scramble();
    ic_addr    = $urandom;
    dc_addr    = $urandom;
    dc_dirty   = 1'($urandom);
    dc_wb_addr = $urandom;
    dc_wb_line = rand_line();
  endtask

  // Serve one grant from the current request pattern. Called at a negedge in
  // which the FSM will sample requests at the next rising edge.
  task automatic serve(input int unsigned wb_lat, input int unsigned fill_lat,
                       input bit scr);
    bit                exp_d;
    bit                is_wb;
    logic [ADDR_W-1:0] s_miss;
    logic [ADDR_W-1:0] s_wba;
    logic [LINE_W-1:0] s_wbl;
    logic [LINE_W-1:0] rd;
    int unsigned       n;
    exp_d  = model_pick(ic_req, dc_req);
    is_wb  = exp_d && dc_dirty;
    s_miss = exp_d ? dc_addr : ic_addr;
    s_wba  = dc_wb_addr;
    s_wbl  = dc_wb_line;
    for (n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (cla_toggle) break;
    end
    chk("issue_delay", n, 1);
    chk("owner", owner, exp_d);
    chk("busy_issue", busy, 1);
    if (is_wb) begin
      chk("wb_we", cla_we, 1);
      chk("wb_re", cla_re, 0);
      chk("wb_addr", mem_addr, aligned(s_wba));
      chk("wb_data", cla_wdata, s_wbl);
      if (scr) scramble();
      for (int i = 1; i <= int'(wb_lat); i++) begin
        @(negedge CLK);
        chk("wb_busy_toggle", cla_toggle, 0);
        chk("wb_busy_we", cla_we, 1);
        chk("wb_busy_re", cla_re, 0);
        chk("wb_busy_addr", mem_addr, aligned(s_wba));
        chk("wb_busy_data", cla_wdata, s_wbl);
        if (i == int'(wb_lat)) cla_ready = 1'b1;
      end
      @(negedge CLK);
      cla_ready = 1'b0;
      chk("wb_to_fill_toggle", cla_toggle, 1);
      chk("wb_to_fill_busy", busy, 1);
    end
    chk("fill_re", cla_re, 1);
    chk("fill_we", cla_we, 0);
    chk("fill_addr", mem_addr, aligned(s_miss));
    if (scr && !is_wb) scramble();
    rd = rand_line();
    for (int i = 1; i <= int'(fill_lat); i++) begin
      @(negedge CLK);
      chk("fill_busy_toggle", cla_toggle, 0);
      chk("fill_busy_re", cla_re, 1);
      chk("fill_busy_we", cla_we, 0);
      chk("fill_busy_addr", mem_addr, aligned(s_miss));
      chk("fill_busy_owner", owner, exp_d);
      if (i == int'(fill_lat)) begin
        cla_rdata = rd;
        cla_ready = 1'b1;
      end
    end
    @(negedge CLK);
    cla_ready = 1'b0;
    chk("ic_ack", ic_ack, !exp_d);
    chk("dc_ack", dc_ack, exp_d);
    chk("ic_line", ic_line, rd);
    chk("dc_line", dc_line, rd);
    chk("ack_re", cla_re, 0);
    chk("ack_we", cla_we, 0);
    chk("ack_toggle", cla_toggle, 0);
    if (exp_d) dc_req = 1'b0;
    else       ic_req = 1'b0;
    last_d = exp_d;
    @(negedge CLK);
    chk("ack_single_ic", ic_ack, 0);
    chk("ack_single_dc", dc_ack, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Raise a request pattern (1=I, 2=D, 3=both) and serve every granted one.
  task automatic round(input int unsigned pat, input bit scr);
    ic_addr    = $urandom;
    dc_addr    = $urandom;
    dc_dirty   = 1'($urandom);
    dc_wb_addr = $urandom;
    dc_wb_line = rand_line();
    ic_req     = pat[0];
    dc_req     = pat[1];
    while (ic_req || dc_req)
      serve($urandom_range(1, 5), $urandom_range(1, 6), scr);
  endtask

  initial begin
    RST        = 1'b0;
    ic_req     = 1'b0;
    ic_addr    = '0;
    dc_req     = 1'b0;
    dc_dirty   = 1'b0;
    dc_addr    = '0;
    dc_wb_addr = '0;
    dc_wb_line = '0;
    cla_rdata  = '0;
    cla_ready  = 1'b0;

    #12;
    chk_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("post_reset");

    // Clean I-fill: ready on cycle 9, ack on cycle 10.
    ic_addr = 32'h0000_1234;
    ic_req  = 1'b1;
    serve(1, 8, 1'b0);
    chk("ifill_err", err, 0);

    // Dirty D-miss: write pass at 0x40 then read pass at 0x80.
    dc_wb_addr = 32'h40;
    dc_addr    = 32'h80;
    dc_dirty   = 1'b1;
    dc_wb_line = rand_line();
    dc_req     = 1'b1;
    serve(3, 4, 1'b0);

    // Randomized rounds with mid-transfer input changes.
    for (int r = 0; r < 30; r++) round($urandom_range(1, 3), 1'b1);
    chk("no_err_yet", err, 0);

    // Stray ready pulse in IDLE.
    cla_ready = 1'b1;
    @(negedge CLK);
    cla_ready = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_busy", busy, 0);
    chk("stray_toggle", cla_toggle, 0);
    @(negedge CLK);
    chk("stray_err_sticky", err, 1);
    chk("stray_idle", busy, 0);
    round(3, 1'b0);
    chk("stray_err_after_txn", err, 1);

    // Async reset while the fill is outstanding.
    ic_addr = $urandom;
    ic_req  = 1'b1;
    @(negedge CLK);
    chk("rst_issue", cla_toggle, 1);
    @(negedge CLK);
    chk("rst_fill_busy", cla_re, 1);
    #2;
    RST    = 1'b0;
    ic_req = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge CLK);
    RST    = 1'b1;
    last_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("no_ack_after_reset_ic", ic_ack, 0);
      chk("no_ack_after_reset_dc", dc_ack, 0);
      chk("idle_after_reset", busy, 0);
    end
    round(1, 1'b0);

    // Simultaneous requests after reset, repeated twice.
    RST = 1'b0;
    @(negedge CLK);
    RST    = 1'b1;
    last_d = 1'b0;
    @(negedge CLK);
    round(3, 1'b0);
    round(3, 1'b0);
    // A lone D-cache transfer followed by a tie separates the two policies.
    round(2, 1'b0);
    round(3, 1'b0);

    for (int r = 0; r < 10; r++) round($urandom_range(1, 3), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
